// File: rtl/fifo_word_uart_tx_pkg.sv
// Shared definitions for the FIFO word-to-UART transmitter: line levels, FSM encodings, frame size.
// Optional even parity bit is enabled by defining FIFO_TX_PARITY_EN.
package fifo_word_uart_tx_pkg;

    localparam int unsigned UART_BITS_PER_BYTE = 8;
    localparam logic        START_LEVEL        = 1'b0;
    localparam logic        STOP_LEVEL         = 1'b1;
    localparam logic        IDLE_LEVEL         = 1'b1;

`ifdef FIFO_TX_PARITY_EN
    localparam int unsigned FRAME_BITS = 11;
`else
    localparam int unsigned FRAME_BITS = 10;
`endif

    typedef enum logic [2:0] {
        W_IDLE,
        W_POP,
        W_LOAD,
        W_SEND,
        W_DONE
    } word_state_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } ser_state_t;

    // Counter width that stays at least one bit for degenerate sizes.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fifo_word_uart_tx_byte.sv
// Single-byte UART serializer: start, 8 data bits LSB first, optional even parity, stop.
// A new byte can be accepted in the last cycle of the stop bit so consecutive frames are gapless.
module fifo_word_uart_tx_byte
    import fifo_word_uart_tx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       byte_valid,
    input  logic [7:0] byte_data,
    output logic       byte_ready_c,
    output logic       frame_done_c,
    output logic       txd
);

    localparam int unsigned BAUD_W = idx_width(CLKS_PER_BIT);

    ser_state_t        state;
    logic [BAUD_W-1:0] baud_cnt;
    logic [2:0]        bit_idx;
    logic [7:0]        shift;
    logic              parity;
    logic              bit_end;

    assign bit_end      = (baud_cnt == BAUD_W'(CLKS_PER_BIT - 1));
    assign frame_done_c = (state == S_STOP) && bit_end;
    assign byte_ready_c = (state == S_IDLE) || frame_done_c;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            parity   <= 1'b0;
            txd      <= IDLE_LEVEL;
        end else if (byte_valid && byte_ready_c) begin
            state    <= S_START;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= byte_data;
            parity   <= ^byte_data;
            txd      <= START_LEVEL;
        end else begin
            case (state)
                S_IDLE: begin
                    baud_cnt <= '0;
                    txd      <= IDLE_LEVEL;
                end
                S_START: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        state    <= S_DATA;
                        txd      <= shift[0];
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_W'(1);
                    end
                end
                S_DATA: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        if (bit_idx == 3'(UART_BITS_PER_BYTE - 1)) begin
                            bit_idx <= '0;
`ifdef FIFO_TX_PARITY_EN
                            state   <= S_PARITY;
                            txd     <= parity;
`else
                            state   <= S_STOP;
                            txd     <= STOP_LEVEL;
`endif
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            shift   <= shift >> 1;
                            txd     <= shift[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_W'(1);
                    end
                end
                S_PARITY: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        state    <= S_STOP;
                        txd      <= STOP_LEVEL;
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_W'(1);
                    end
                end
                S_STOP: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        state    <= S_IDLE;
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_W'(1);
                    end
                    txd <= STOP_LEVEL;
                end
                default: begin
                    state <= S_IDLE;
                    txd   <= IDLE_LEVEL;
                end
            endcase
        end
    end

endmodule

// File: rtl/fifo_word_uart_tx.sv
// FIFO read-side consumer: pops DATA_W-bit words and sends them LSB byte first over UART.
// Build option: FIFO_TX_PARITY_EN adds an even parity bit to every byte frame.
module fifo_word_uart_tx
    import fifo_word_uart_tx_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CLK_HZ = 100_000_000,
    parameter int unsigned BAUD   = 115200
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tx_enable,
    input  logic              fifo_empty,
    output logic              fifo_rd_en,
    input  logic [DATA_W-1:0] fifo_rd_data,
    output logic              uart_txd,
    output logic              busy,
    output logic              word_done
);

    localparam int unsigned CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int unsigned BYTES        = DATA_W / 8;
    localparam int unsigned BYTE_IDX_W   = idx_width(BYTES);
    localparam int unsigned LAST_BYTE    = BYTES - 1;

    word_state_t           state;
    logic [DATA_W-1:0]     word_reg;
    logic [BYTE_IDX_W-1:0] byte_idx;
    logic                  byte_valid_c;
    logic [7:0]            byte_data_c;
    logic                  byte_ready_c;
    logic                  frame_done_c;

    // First byte goes straight from the FIFO read data; the rest come from the shifted word register.
    assign byte_valid_c = (state == W_LOAD) ||
                          ((state == W_SEND) && (byte_idx != BYTE_IDX_W'(LAST_BYTE)));
    assign byte_data_c  = (state == W_LOAD) ? fifo_rd_data[7:0] : word_reg[7:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= W_IDLE;
            word_reg   <= '0;
            byte_idx   <= '0;
            fifo_rd_en <= 1'b0;
            busy       <= 1'b0;
            word_done  <= 1'b0;
        end else begin
            fifo_rd_en <= 1'b0;
            word_done  <= 1'b0;
            case (state)
                W_IDLE: begin
                    busy <= 1'b0;
                    if (tx_enable && !fifo_empty) begin
                        state      <= W_POP;
                        fifo_rd_en <= 1'b1;
                        busy       <= 1'b1;
                    end
                end
                W_POP: begin
                    state <= W_LOAD;
                end
                W_LOAD: begin
                    word_reg <= fifo_rd_data >> 8;
                    byte_idx <= '0;
                    state    <= W_SEND;
                end
                W_SEND: begin
                    if (byte_valid_c && byte_ready_c) begin
                        word_reg <= word_reg >> 8;
                        byte_idx <= byte_idx + BYTE_IDX_W'(1);
                    end else if (frame_done_c) begin
                        state     <= W_DONE;
                        word_done <= 1'b1;
                    end
                end
                W_DONE: begin
                    busy  <= 1'b0;
                    state <= W_IDLE;
                end
                default: begin
                    state <= W_IDLE;
                end
            endcase
        end
    end

    fifo_word_uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_byte_tx (
        .clk         (clk),
        .rst         (rst),
        .byte_valid  (byte_valid_c),
        .byte_data   (byte_data_c),
        .byte_ready_c(byte_ready_c),
        .frame_done_c(frame_done_c),
        .txd         (uart_txd)
    );

endmodule

// File: tb/tb_fifo_word_uart_tx.sv
// Bench for fifo_word_uart_tx: behavioural FIFO, mid-bit sampling UART receiver, byte-stream scoreboard.
module tb_fifo_word_uart_tx;

    localparam int unsigned CPB = 16;
`ifdef FIFO_TX_PARITY_EN
    localparam int unsigned FRAME = 11;
`else
    localparam int unsigned FRAME = 10;
`endif
    localparam int unsigned WORD_CYC = 4 * FRAME * CPB;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tx_enable = 1'b0;
    logic        fifo_empty;
    logic        fifo_rd_en;
    logic [31:0] fifo_rd_data = '0;
    logic        uart_txd;
    logic        busy;
    logic        word_done;

    fifo_word_uart_tx #(.DATA_W(32), .CLK_HZ(16), .BAUD(1)) dut (
        .clk         (clk),
        .rst         (rst),
        .tx_enable   (tx_enable),
        .fifo_empty  (fifo_empty),
        .fifo_rd_en  (fifo_rd_en),
        .fifo_rd_data(fifo_rd_data),
        .uart_txd    (uart_txd),
        .busy        (busy),
        .word_done   (word_done)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;

    // Behavioural FIFO: data appears the cycle after the pop strobe
    logic [31:0] mem [256];
    int wr_ptr = 0;
    int rd_ptr = 0;
    int pop_empty_err = 0;
    int pops = 0;
    int done_cnt = 0;
    int epoch = 0;
    longint cyc = 0;
    assign fifo_empty = (wr_ptr == rd_ptr);

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) epoch <= epoch + 1;
        if (word_done === 1'b1) done_cnt <= done_cnt + 1;
        if (fifo_rd_en === 1'b1) begin
            pops <= pops + 1;
            if (rd_ptr == wr_ptr) pop_empty_err <= pop_empty_err + 1;
            fifo_rd_data <= mem[rd_ptr[7:0]];
            rd_ptr <= rd_ptr + 1;
        end
    end

    // UART receiver: samples each bit at its middle; frames cut by reset are dropped
    logic [7:0] rx_q [$];
    int stop_err = 0;
    int parity_err = 0;
    initial begin
        logic [7:0] d;
        logic       p;
        logic       s;
        int         e0;
        @(negedge rst);
        forever begin
            @(negedge clk);
            if (uart_txd === 1'b0 && rst === 1'b0) begin
                e0 = epoch;
                repeat (CPB / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    d[i] = uart_txd;
                end
                p = ^d;
`ifdef FIFO_TX_PARITY_EN
                repeat (CPB) @(negedge clk);
                p = uart_txd;
`endif
                repeat (CPB) @(negedge clk);
                s = uart_txd;
                if (epoch == e0) begin
                    rx_q.push_back(d);
                    if (s !== 1'b1) stop_err++;
                    if (p !== ^d) parity_err++;
                end
            end
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", nm, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] w);
        mem[wr_ptr[7:0]] = w;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic wait_rd(input string nm, output longint t);
        int k = 0;
        while (fifo_rd_en !== 1'b1 && k < 3000) begin
            @(negedge clk);
            k++;
        end
        check({nm, " pop seen"}, 32'(fifo_rd_en), 32'd1);
        t = cyc;
    endtask

    task automatic wait_done(input string nm, output longint t);
        int k = 0;
        while (word_done !== 1'b1 && k < 3000) begin
            @(negedge clk);
            k++;
        end
        check({nm, " word_done seen"}, 32'(word_done), 32'd1);
        t = cyc;
        @(negedge clk);
    endtask

    // Compare received bytes from index base against the LSB-first bytes of a word
    task automatic check_word(input string nm, input int base, input logic [31:0] w);
        logic [31:0] tmp;
        tmp = w;
        for (int k = 0; k < 4; k++) begin
            if (base + k < rx_q.size())
                check($sformatf("%s byte%0d", nm, k), 32'(rx_q[base + k]), 32'(tmp[7:0]));
            else
                check($sformatf("%s byte%0d missing", nm, k), 32'(rx_q.size()), 32'(base + k + 1));
            tmp = tmp >> 8;
        end
    endtask

    typedef struct {
        logic [31:0] word;
        logic [31:0] exp_seq;   // bytes in line order, first byte in [31:24]
    } vec_t;

    vec_t tbl [6];

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        longint t0, t1, t2;
        int base, p0, d0, low_cnt, rd_cnt;
        logic [31:0] rw [$];

        tbl[0] = '{32'hA55A0F01, {8'h01, 8'h0F, 8'h5A, 8'hA5}};
        tbl[1] = '{32'h00000000, {8'h00, 8'h00, 8'h00, 8'h00}};
        tbl[2] = '{32'hFFFFFFFF, {8'hFF, 8'hFF, 8'hFF, 8'hFF}};
        tbl[3] = '{32'h12345678, {8'h78, 8'h56, 8'h34, 8'h12}};
        tbl[4] = '{32'h80000001, {8'h01, 8'h00, 8'h00, 8'h80}};
        tbl[5] = '{32'h00000007, {8'h07, 8'h00, 8'h00, 8'h00}};

        tx_enable = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset txd", 32'(uart_txd), 32'd1);
        check("reset rd_en", 32'(fifo_rd_en), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset word_done", 32'(word_done), 32'd0);
        rst = 1'b0;

        low_cnt = 0;
        rd_cnt = 0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (fifo_rd_en === 1'b1) rd_cnt++;
            if (uart_txd !== 1'b1) low_cnt++;
        end
        check("empty no pop", 32'(rd_cnt), 32'd0);
        check("empty txd idle", 32'(low_cnt), 32'd0);

        for (int i = 0; i < 6; i++) begin
            base = rx_q.size();
            p0 = pops;
            push(tbl[i].word);
            wait_rd($sformatf("vec%0d", i), t0);
            check($sformatf("vec%0d busy at pop", i), 32'(busy), 32'd1);
            wait_done($sformatf("vec%0d", i), t1);
            check($sformatf("vec%0d latency", i), 32'(t1 - t0), 32'(WORD_CYC + 2));
            check($sformatf("vec%0d busy after", i), 32'(busy), 32'd0);
            check($sformatf("vec%0d pops", i), 32'(pops - p0), 32'd1);
            for (int k = 0; k < 4; k++) begin
                if (base + k < rx_q.size())
                    check($sformatf("vec%0d byte%0d", i, k), 32'(rx_q[base + k]),
                          32'((tbl[i].exp_seq >> (24 - 8 * k)) & 32'hFF));
                else
                    check($sformatf("vec%0d byte%0d missing", i, k), 32'(rx_q.size()), 32'(base + k + 1));
            end
        end

        // Back-to-back words: only DONE, IDLE, POP, LOAD between frames
        base = rx_q.size();
        p0 = pops;
        push(32'h00000000);
        push(32'hFFFFFFFF);
        wait_done("b2b w0", t1);
        wait_done("b2b w1", t2);
        check("b2b gap", 32'(t2 - t1), 32'(WORD_CYC + 4));
        check("b2b pops", 32'(pops - p0), 32'd2);
        check_word("b2b w0", base, 32'h00000000);
        check_word("b2b w1", base + 4, 32'hFFFFFFFF);

        // tx_enable dropped during the first byte: word completes, no further pop
        base = rx_q.size();
        p0 = pops;
        push(32'h12345678);
        push(32'h9ABCDEF0);
        wait_rd("txen", t0);
        repeat (80) @(negedge clk);
        tx_enable = 1'b0;
        wait_done("txen w0", t1);
        repeat (300) @(negedge clk);
        check("txen pops", 32'(pops - p0), 32'd1);
        check("txen fifo still full", 32'(fifo_empty), 32'd0);
        check("txen idle txd", 32'(uart_txd), 32'd1);
        check_word("txen w0", base, 32'h12345678);
        tx_enable = 1'b1;
        wait_done("txen w1", t1);
        check_word("txen w1", base + 4, 32'h9ABCDEF0);

        // Random words in bursts, checked against the LSB-first byte stream model
        for (int b = 0; b < 3; b++) begin
            base = rx_q.size();
            rw.delete();
            for (int j = 0; j < 4; j++) begin
                rw.push_back($urandom);
                push(rw[j]);
            end
            for (int j = 0; j < 4; j++) wait_done($sformatf("rand b%0d w%0d", b, j), t1);
            for (int j = 0; j < 4; j++) check_word($sformatf("rand b%0d w%0d", b, j), base + 4 * j, rw[j]);
            repeat ($urandom_range(0, 20)) @(negedge clk);
        end

        // Reset during the data bits of the second byte
        base = rx_q.size();
        push(32'h12345678);
        wait_rd("rst", t0);
        repeat (2 + FRAME * CPB + CPB + 40) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst mid txd", 32'(uart_txd), 32'd1);
        check("rst mid busy", 32'(busy), 32'd0);
        check("rst mid word_done", 32'(word_done), 32'd0);
        rst = 1'b0;
        d0 = done_cnt;
        repeat (900) @(negedge clk);
        check("rst no word_done", 32'(done_cnt - d0), 32'd0);
        check("rst bytes before reset", 32'(rx_q.size() - base), 32'd1);
        if (rx_q.size() > base) check("rst byte0", 32'(rx_q[base]), 32'h78);

        check("pop while empty", 32'(pop_empty_err), 32'd0);
        check("stop bit errors", 32'(stop_err), 32'd0);
        check("parity errors", 32'(parity_err), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
